keypad_entry: RTL and testbench

//   Input-side counterpart of the seven-segment display path: scans a 4x4 matrix keypad,

---
 rtl/keypad_entry.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_entry.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// ============================================================================
// Module   : keypad_entry
// Purpose  : Scans a 4x4 active-low matrix keypad, debounces each press and
//            release, and decodes the key to a 4-bit code. Digit keys build a
//            13-bit binary entry value together with its 4-digit BCD image.
//            '*' clears the entry and '#' commits it to value_out.
// Ports    : clk        - system clock, all logic on posedge
//            rst_n      - asynchronous active-low reset
//            row_in     - keypad rows, active-low, already synchronised
//            col_out    - keypad column drive, active-low one-hot
//            clear      - synchronous entry clear (same effect as '*')
//            key_valid  - 1-cycle pulse, debounced key accepted
//            key_code   - code of last accepted key
//            digits     - BCD {thousands,hundreds,tens,ones} of value
//            value      - binary entry value under construction
//            value_out  - last committed value
//            commit     - 1-cycle pulse, value_out updated
//            overflow   - 1-cycle pulse, digit rejected (result > 8191)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry #(
  parameter int SCAN_DIV     = 2**16,
  parameter int DEBOUNCE_CNT = 2**18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [12:0] value,
  output logic [12:0] value_out,
  output logic        commit,
  output logic        overflow
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_out_q, col_out_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]    rows_q, rows_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic [12:0]   value_q, value_d;
  logic [15:0]   digits_q, digits_d;
  logic [12:0]   value_out_q, value_out_d;
  logic          commit_q, commit_d;
  logic          overflow_q, overflow_d;
  logic [16:0]   w_next_value;

  // Lowest-index low row wins when several rows are pressed in one column.
  function automatic logic [3:0] decode_key(input logic [1:0] col, input logic [3:0] rows);
    logic [1:0] r;
    logic [3:0] code;
    r = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    case ({r, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Scan / debounce / hold sequencing. col_q stays frozen outside ST_SCAN, so it
  // doubles as the latched column index of the key being debounced.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    rows_d      = rows_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    case (state_q)
      ST_SCAN: begin
        if (row_in != 4'hF) begin
          rows_d   = row_in;
          db_cnt_d = '0;
          state_d  = ST_DEBOUNCE;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (row_in != rows_q) begin
          state_d    = ST_SCAN;
          db_cnt_d   = '0;
          scan_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_HELD;
          db_cnt_d    = '0;
          key_valid_d = 1'b1;
          key_code_d  = decode_key(col_q, rows_q);
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (row_in != 4'hF) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_SCAN;
          db_cnt_d   = '0;
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
    col_out_d = ~(4'b0001 << col_d);
  end

  // Entry update acts on the registered key pulse, so results appear one cycle
  // after key_valid. Accepted values are <= 8191, hence value <= 819 before the
  // shift and the dropped thousands digit is always zero.
  assign w_next_value = {4'd0, value_q} * 17'd10 + {13'd0, key_code_q};

  always_comb begin
    value_d     = value_q;
    digits_d    = digits_q;
    value_out_d = value_out_q;
    commit_d    = 1'b0;
    overflow_d  = 1'b0;
    if (key_valid_q) begin
      if (key_code_q <= 4'd9) begin
        if (!clear) begin
          if (w_next_value <= 17'd8191) begin
            value_d  = w_next_value[12:0];
            digits_d = {digits_q[11:0], key_code_q};
          end else begin
            overflow_d = 1'b1;
          end
        end
      end else if (key_code_q == 4'hF) begin
        // Commit sees the pre-clear value even when clear is asserted.
        value_out_d = value_q;
        commit_d    = 1'b1;
      end else if (key_code_q == 4'hE) begin
        value_d  = '0;
        digits_d = '0;
      end
    end
    if (clear) begin
      value_d  = '0;
      digits_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      col_out_q   <= 4'b1110;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      rows_q      <= 4'hF;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      value_q     <= '0;
      digits_q    <= '0;
      value_out_q <= '0;
      commit_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      col_out_q   <= col_out_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      rows_q      <= rows_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      value_q     <= value_d;
      digits_q    <= digits_d;
      value_out_q <= value_out_d;
      commit_q    <= commit_d;
      overflow_q  <= overflow_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digits    = digits_q;
  assign value     = value_q;
  assign value_out = value_out_q;
  assign commit    = commit_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry.sv
// ============================================================================
// Module   : tb_keypad_entry
// Purpose  : Self-checking bench for keypad_entry. A keypad model drives
//            row_in from col_out; expected key results and state snapshots
//            are queued by the stimulus and checked by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_entry;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [12:0] value;
  logic [12:0] value_out;
  logic        commit;
  logic        overflow;

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .clear(clear),
    .key_valid(key_valid), .key_code(key_code), .digits(digits), .value(value),
    .value_out(value_out), .commit(commit), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: the pressed key pulls its row low only while its column is driven.
  logic       pressed;
  logic [1:0] pr, pc;
  assign row_in = (pressed && !col_out[pc]) ? ~(4'b0001 << pr) : 4'hF;

  typedef struct {
    logic [3:0]  code;
    logic [12:0] val;
    logic [15:0] dig;
    logic [12:0] vout;
    logic        com;
    logic        ovf;
  } key_exp_t;

  typedef struct {
    logic [12:0] val;
    logic [15:0] dig;
    logic [12:0] vout;
    logic [3:0]  col;
    logic        end_chk;
  } snap_t;

  key_exp_t key_q[$];
  snap_t    chk_q[$];
  int       n_vec = 0;
  int       n_err = 0;

  // ---------------------------------------------------------------- monitor
  logic     pend = 1'b0;
  key_exp_t pend_e;

  always @(negedge clk) begin
    key_exp_t e;
    snap_t    s;
    if (pend) begin
      n_vec++;
      pend = 1'b0;
      if (value !== pend_e.val || digits !== pend_e.dig || value_out !== pend_e.vout ||
          commit !== pend_e.com || overflow !== pend_e.ovf) begin
        n_err++;
        $display("FAIL entry_result: got value=%0d digits=%h value_out=%0d commit=%b overflow=%b, want value=%0d digits=%h value_out=%0d commit=%b overflow=%b",
                 value, digits, value_out, commit, overflow,
                 pend_e.val, pend_e.dig, pend_e.vout, pend_e.com, pend_e.ovf);
      end
    end else if (commit || overflow) begin
      n_vec++;
      n_err++;
      $display("FAIL spurious_pulse: got commit=%b overflow=%b, want both 0", commit, overflow);
    end
    if (key_valid) begin
      n_vec++;
      if (key_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_key: got key_valid with code %h, want no key_valid", key_code);
      end else begin
        e = key_q.pop_front();
        if (key_code !== e.code) begin
          n_err++;
          $display("FAIL key_code: got %h, want %h", key_code, e.code);
        end
        pend   = 1'b1;
        pend_e = e;
      end
    end
    if (chk_q.size() > 0) begin
      s = chk_q.pop_front();
      n_vec++;
      if (s.end_chk) begin
        if (key_q.size() != 0) begin
          n_err++;
          $display("FAIL missing_keys: got %0d expected keys never seen, want 0", key_q.size());
        end
      end else if (value !== s.val || digits !== s.dig || value_out !== s.vout ||
                   col_out !== s.col || key_valid !== 1'b0) begin
        n_err++;
        $display("FAIL snapshot: got value=%0d digits=%h value_out=%0d col_out=%b key_valid=%b, want value=%0d digits=%h value_out=%0d col_out=%b key_valid=0",
                 value, digits, value_out, col_out, key_valid, s.val, s.dig, s.vout, s.col);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic exp_key(input logic [3:0] code, input int v, input logic [15:0] d,
                         input int vo, input logic com, input logic ovf);
    key_exp_t e;
    e.code = code; e.val = 13'(v); e.dig = d; e.vout = 13'(vo); e.com = com; e.ovf = ovf;
    key_q.push_back(e);
  endtask

  task automatic exp_snap(input int v, input logic [15:0] d, input int vo, input logic [3:0] col);
    snap_t s;
    s.val = 13'(v); s.dig = d; s.vout = 13'(vo); s.col = col; s.end_chk = 1'b0;
    chk_q.push_back(s);
    repeat (2) @(posedge clk);
  endtask

  task automatic press(input int r, input int c, input int hold);
    pr = 2'(r); pc = 2'(c);
    pressed = 1'b1;
    repeat (hold) @(posedge clk);
    #1 pressed = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  // Presses a key and raises clear exactly in the cycle key_valid is high.
  task automatic press_with_clear(input int r, input int c);
    pr = 2'(r); pc = 2'(c);
    pressed = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (key_valid) break;
    end
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (20) @(posedge clk);
    #1 pressed = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  initial begin
    snap_t s;
    rst_n = 1'b0; clear = 1'b0; pressed = 1'b0; pr = 2'd0; pc = 2'd0;
    repeat (2) @(posedge clk);
    exp_snap(0, 16'h0000, 0, 4'b1110);
    #1 rst_n = 1'b1;

    // Single press of '6'
    exp_key(4'h6, 6, 16'h0006, 0, 1'b0, 1'b0);
    press(1, 2, 60);
    exp_key(4'hE, 0, 16'h0000, 0, 1'b0, 1'b0);
    press(3, 0, 60);

    // Bouncing '7' : on/off every 10 clocks, then stable
    exp_key(4'h7, 7, 16'h0007, 0, 1'b0, 1'b0);
    pr = 2'd2; pc = 2'd0;
    for (int i = 0; i < 5; i++) begin
      pressed = (i % 2 == 0);
      repeat (10) @(posedge clk);
    end
    pressed = 1'b1;
    repeat (60) @(posedge clk);
    #1 pressed = 1'b0;
    repeat (40) @(posedge clk);
    exp_key(4'hE, 0, 16'h0000, 0, 1'b0, 1'b0);
    press(3, 0, 60);

    // 8,1,9,1,# then 5 overflows
    exp_key(4'h8, 8,    16'h0008, 0,    1'b0, 1'b0); press(2, 1, 60);
    exp_key(4'h1, 81,   16'h0081, 0,    1'b0, 1'b0); press(0, 0, 60);
    exp_key(4'h9, 819,  16'h0819, 0,    1'b0, 1'b0); press(2, 2, 60);
    exp_key(4'h1, 8191, 16'h8191, 0,    1'b0, 1'b0); press(0, 0, 60);
    exp_key(4'hF, 8191, 16'h8191, 8191, 1'b1, 1'b0); press(3, 2, 60);
    exp_key(4'h5, 8191, 16'h8191, 8191, 1'b0, 1'b1); press(1, 1, 60);

    // Long hold of 'A', short release glitch, re-press: one pulse only
    exp_key(4'hA, 8191, 16'h8191, 8191, 1'b0, 1'b0);
    pr = 2'd0; pc = 2'd3;
    pressed = 1'b1;
    repeat (5 * DEBOUNCE_CNT) @(posedge clk);
    #1 pressed = 1'b0;
    repeat (8) @(posedge clk);
    #1 pressed = 1'b1;
    repeat (40) @(posedge clk);
    #1 pressed = 1'b0;
    repeat (40) @(posedge clk);

    // 123, then clear together with '4', then '*', then leading zero
    exp_key(4'hE, 0,   16'h0000, 8191, 1'b0, 1'b0); press(3, 0, 60);
    exp_key(4'h1, 1,   16'h0001, 8191, 1'b0, 1'b0); press(0, 0, 60);
    exp_key(4'h2, 12,  16'h0012, 8191, 1'b0, 1'b0); press(0, 1, 60);
    exp_key(4'h3, 123, 16'h0123, 8191, 1'b0, 1'b0); press(0, 2, 60);
    exp_key(4'h4, 0,   16'h0000, 8191, 1'b0, 1'b0); press_with_clear(1, 0);
    exp_key(4'hE, 0,   16'h0000, 8191, 1'b0, 1'b0); press(3, 0, 60);
    exp_key(4'h0, 0,   16'h0000, 8191, 1'b0, 1'b0); press(3, 1, 60);

    // Reset in the middle of debouncing '2'
    pr = 2'd0; pc = 2'd1;
    pressed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (row_in != 4'hF) break;
    end
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_snap(0, 16'h0000, 0, 4'b1110);
    pressed = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_snap(0, 16'h0000, 0, 4'b1110);
    repeat (40) @(posedge clk);

    s.val = '0; s.dig = '0; s.vout = '0; s.col = '0; s.end_chk = 1'b1;
    chk_q.push_back(s);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
